des_key_schedule_iterative: RTL and testbench

//  Iterative DES key schedule feeding the 16-stage pipelined DES encryption core.

---
 rtl/des_key_schedule_iterative_if.sv | 19 +
 rtl/des_key_schedule_iterative.sv | 106 ++++++++++
 tb/tb_des_key_schedule_iterative.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/des_key_schedule_iterative_if.sv
// Request/result bundle between a DES key-schedule engine and its consumer.
// master = key requester / round-key consumer, slave = schedule engine.
interface des_key_schedule_iterative_if;
  logic         start;
  logic [63:0]  key;
  logic         busy;
  logic         keys_valid;
  logic [767:0] round_keys;

  modport master (
    output start, key,
    input  busy, keys_valid, round_keys
  );

  modport slave (
    input  start, key,
    output busy, keys_valid, round_keys
  );
endinterface

// File: rtl/des_key_schedule_iterative.sv
// Iterative DES key schedule: PC-1, one C/D rotate + PC-2 per clock, 16 round keys on a 768-bit bus.
// Latency 16 clocks from accepted start to keys_valid; start is ignored while busy, restarts from DONE.
module des_key_schedule_iterative #(
  parameter bit REVERSE_ORDER = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  des_key_schedule_iterative_if.slave ks
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Entries are 1-based FIPS 46-3 bit positions (bit 1 = MSB).
  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1_TBL[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2_TBL[i])];
    return r;
  endfunction

  state_t       state;
  logic [4:0]   round;
  logic [27:0]  c, d;
  logic         busy, keys_valid;
  logic [767:0] round_keys;

  logic         two_step;
  logic [27:0]  c_rot, d_rot;
  logic [47:0]  k_round;
  logic [4:0]   slot;

  // Rounds 1, 2, 9 and 16 rotate by one; every other round by two.
  always_comb begin
    two_step = !(round == 5'd1 || round == 5'd2 || round == 5'd9 || round == 5'd16);
    c_rot    = two_step ? {c[25:0], c[27:26]} : {c[26:0], c[27]};
    d_rot    = two_step ? {d[25:0], d[27:26]} : {d[26:0], d[27]};
    k_round  = pc2({c_rot, d_rot});
    slot     = REVERSE_ORDER ? 5'd17 - round : round;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      round      <= '0;
      c          <= '0;
      d          <= '0;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      round_keys <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (ks.start) begin
            {c, d}     <= pc1(ks.key);
            round      <= 5'd1;
            keys_valid <= 1'b0;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          c <= c_rot;
          d <= d_rot;
          for (int s = 1; s <= 16; s++) begin
            if (slot == 5'(s)) round_keys[768 - 48*s +: 48] <= k_round;
          end
          if (round == 5'd16) begin
            busy       <= 1'b0;
            keys_valid <= 1'b1;
            round      <= '0;
            state      <= DONE;
          end else begin
            round <= round + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ks.busy       = busy;
  assign ks.keys_valid = keys_valid;
  assign ks.round_keys = round_keys;

endmodule

// File: tb/tb_des_key_schedule_iterative.sv
// Bench for des_key_schedule_iterative: forward and reverse-ordered instances driven in lockstep,
// known FIPS vectors in a table plus a bit-level DES key-schedule model for random keys.
module tb_des_key_schedule_iterative;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  des_key_schedule_iterative_if ifc0 ();
  des_key_schedule_iterative_if ifc1 ();

  des_key_schedule_iterative #(.REVERSE_ORDER(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .ks(ifc0));
  des_key_schedule_iterative #(.REVERSE_ORDER(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .ks(ifc1));

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct {
    logic [63:0] key;
    bit          rev;
    int          slot;
    logic [47:0] exp;
  } vec_t;

  vec_t tbl [8];
  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt, early, rise, lat;
  logic [63:0] key_a, key_b;

  // Round key r from the total rotation applied to the PC-1 halves since the start.
  function automatic logic [47:0] model_rk(input logic [63:0] k, input int r);
    int total;
    logic [28:1] c0, d0;
    logic [56:1] cd;
    logic [47:0] res;
    total = 0;
    for (int i = 0; i < r; i++) total += SHIFTS[i];
    for (int j = 1; j <= 28; j++) begin
      c0[5'(j)] = k[6'(64 - PC1[j-1])];
      d0[5'(j)] = k[6'(64 - PC1[j+27])];
    end
    for (int j = 1; j <= 28; j++) begin
      cd[6'(j)]      = c0[5'(((j - 1 + total) % 28) + 1)];
      cd[6'(j + 28)] = d0[5'(((j - 1 + total) % 28) + 1)];
    end
    for (int m = 1; m <= 48; m++) res[6'(48 - m)] = cd[6'(PC2[m-1])];
    return res;
  endfunction

  function automatic logic [47:0] slot_of(input logic [767:0] rk, input int s);
    return rk[10'(768 - 48*s) +: 48];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [63:0] k);
    ifc0.start = s;
    ifc0.key   = k;
    ifc1.start = s;
    ifc1.key   = k;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!ifc0.keys_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic check_sched(input logic [63:0] k, input string name);
    for (int s = 1; s <= 16; s++) begin
      chk($sformatf("%s fwd slot%0d", name, s), 64'(slot_of(ifc0.round_keys, s)), 64'(model_rk(k, s)));
      chk($sformatf("%s rev slot%0d", name, s), 64'(slot_of(ifc1.round_keys, s)), 64'(model_rk(k, 17 - s)));
    end
  endtask

  task automatic expand(input logic [63:0] k, input string name);
    int n;
    drive(1'b1, k);
    tick();
    drive(1'b0, {$urandom, $urandom});
    chk({name, " valid low after accept"}, 64'(ifc0.keys_valid), 64'd0);
    chk({name, " busy after accept"}, 64'(ifc0.busy), 64'd1);
    wait_valid(n);
    chk({name, " latency"}, 64'(n), 64'd16);
    chk({name, " busy at done"}, 64'(ifc0.busy), 64'd0);
    chk({name, " rev valid"}, 64'(ifc1.keys_valid), 64'd1);
    check_sched(k, name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{64'h133457799BBCDFF1, 1'b0,  1, 48'h1B02EFFC7072};
    tbl[1] = '{64'h133457799BBCDFF1, 1'b0,  2, 48'h79AED9DBC9E5};
    tbl[2] = '{64'h133457799BBCDFF1, 1'b0,  3, 48'h55FC8A42CF99};
    tbl[3] = '{64'h133457799BBCDFF1, 1'b0, 16, 48'hCB3D8B0E17F5};
    tbl[4] = '{64'h133457799BBCDFF1, 1'b1,  1, 48'hCB3D8B0E17F5};
    tbl[5] = '{64'h133457799BBCDFF1, 1'b1, 16, 48'h1B02EFFC7072};
    tbl[6] = '{64'h133457799BBCDFF1, 1'b1, 15, 48'h79AED9DBC9E5};
    tbl[7] = '{64'h133457799BBCDFF1, 1'b1, 14, 48'h55FC8A42CF99};

    rst_n = 1'b0;
    drive(1'b0, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(ifc0.busy), 64'd0);
    chk("reset keys_valid", 64'(ifc0.keys_valid), 64'd0);
    chk("reset round_keys", 64'(|ifc0.round_keys), 64'd0);
    chk("reset rev round_keys", 64'(|ifc1.round_keys), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle hold busy", 64'(ifc0.busy), 64'd0);

    // Single start pulse; key changes right after acceptance must not matter.
    drive(1'b1, tbl[0].key);
    tick();
    drive(1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    busy_cnt = 0;
    early    = 0;
    for (int i = 0; i < 16; i++) begin
      if (ifc0.busy) busy_cnt++;
      if (ifc0.keys_valid) early++;
      tick();
    end
    chk("t1 busy cycles", 64'(busy_cnt), 64'd16);
    chk("t1 early valid", 64'(early), 64'd0);
    chk("t1 keys_valid", 64'(ifc0.keys_valid), 64'd1);
    chk("t1 busy done", 64'(ifc0.busy), 64'd0);

    for (int i = 0; i < 8; i++) begin
      chk($sformatf("vec%0d slot%0d rev%0d", i, tbl[i].slot, tbl[i].rev),
          64'(slot_of(tbl[i].rev ? ifc1.round_keys : ifc0.round_keys, tbl[i].slot)), 64'(tbl[i].exp));
    end
    check_sched(tbl[0].key, "t1");

    // Start held for 20 cycles: one expansion, then a restart from DONE with the then-current key.
    key_a = {$urandom, $urandom};
    key_b = {$urandom, $urandom};
    drive(1'b1, key_a);
    tick();
    drive(1'b1, key_b);
    busy_cnt = 0;
    early    = 0;
    for (int i = 0; i < 16; i++) begin
      if (ifc0.busy) busy_cnt++;
      if (ifc0.keys_valid) early++;
      tick();
    end
    chk("t3 busy cycles", 64'(busy_cnt), 64'd16);
    chk("t3 early valid", 64'(early), 64'd0);
    chk("t3 valid at E16", 64'(ifc0.keys_valid), 64'd1);
    check_sched(key_a, "t3 first");
    tick();
    chk("t3 valid dropped on restart", 64'(ifc0.keys_valid), 64'd0);
    chk("t3 busy on restart", 64'(ifc0.busy), 64'd1);
    tick();
    tick();
    drive(1'b0, {$urandom, $urandom});
    wait_valid(lat);
    chk("t3 second latency", 64'(lat), 64'd14);
    check_sched(key_b, "t3 second");

    // Start pulse during round 5 is ignored.
    key_a = {$urandom, $urandom};
    key_b = {$urandom, $urandom};
    drive(1'b1, key_a);
    tick();
    drive(1'b0, 64'd0);
    rise = 0;
    for (int e = 1; e <= 20; e++) begin
      if (e == 5) drive(1'b1, key_b);
      else if (e == 6) drive(1'b0, 64'd0);
      tick();
      if (ifc0.keys_valid && rise == 0) rise = e;
    end
    chk("t4 valid rise edge", 64'(rise), 64'd16);
    check_sched(key_a, "t4");

    // Asynchronous reset in round 8, then a fresh key.
    drive(1'b1, {$urandom, $urandom});
    tick();
    drive(1'b0, 64'd0);
    repeat (7) tick();
    chk("t5 busy before reset", 64'(ifc0.busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5 reset busy", 64'(ifc0.busy), 64'd0);
    chk("t5 reset keys_valid", 64'(ifc0.keys_valid), 64'd0);
    chk("t5 reset round_keys", 64'(|ifc0.round_keys), 64'd0);
    chk("t5 reset rev busy", 64'(ifc1.busy), 64'd0);
    chk("t5 reset rev round_keys", 64'(|ifc1.round_keys), 64'd0);
    tick();
    chk("t5 held in reset valid", 64'(ifc0.keys_valid), 64'd0);
    rst_n = 1'b1;
    tick();
    expand(64'h0E329232EA6D0D73, "t5");

    // Back-to-back: new key accepted straight from DONE.
    expand({$urandom, $urandom}, "t6");

    for (int r = 0; r < 3; r++) expand({$urandom, $urandom}, $sformatf("rnd%0d", r));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
